// File: rtl/stream_realigner.sv
// stream_realigner
//   Converts a stream of 128-bit little-endian memory beats, whose first valid
//   byte sits at a byte offset, into a stream of aligned 128-bit words.
//   When the offset is non-zero, one extra beat is read first to prime the
//   residual register. Each output word then combines the tail of the
//   residual with the head of the newly accepted beat.
//
//   Build option: define STREAM_REALIGNER_PERF_CNT_EN to add the stall_cnt
//   output. It is a saturating count of cycles in which an output word was
//   offered and not taken.
//
//   Handshake rule (both ports): a transfer happens on a rising clock edge
//   where valid and ready are both 1. A producer that raises valid holds its
//   data and valid stable until that edge. Ready may depend combinationally
//   on the state and on out_valid/out_ready. Valid never depends on ready.
module stream_realigner #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       start_offset,
    input  logic [LEN_W-1:0] num_words,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
`ifdef STREAM_REALIGNER_PERF_CNT_EN
    output logic [31:0]      stall_cnt,
`endif
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         off_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [127:0]       residual;
    logic [127:0]       merged;
    logic               start_ok;
    logic               in_fire;
    logic               out_fire;
    logic               stream_load;
    logic               final_load;

    // A start is only honoured while idle; the transfer it begins is "accepted".
    assign start_ok    = (state == IDLE) && start;
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign stream_load = (state == STREAM) && in_fire;
    // The word counter holds the words still to be loaded, so 1 means this load is the last.
    assign final_load  = stream_load && (cnt_q == LEN_W'(1));

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Byte realignment: with offset off, output byte j is byte j+off of
    // {new beat, residual}. Offset 0 needs no residual, so the new beat
    // passes straight through.
    assign merged = (off_q == 4'd0) ? in_data
                                    : 128'({in_data, residual} >> {off_q, 3'b000});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and in_ready decode.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (start && (num_words != '0)) begin
                    state_nxt = (start_offset != 4'd0) ? PRIME : STREAM;
                end
            end
            PRIME: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                // Only load when the output register is empty or is being emptied now.
                in_ready = !out_valid || out_ready;
                if (in_valid && (!out_valid || out_ready) && (cnt_q == LEN_W'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Transfer parameters: capture offset and word count on an accepted start, then count loads down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q <= 4'd0;
            cnt_q <= '0;
        end else if (start_ok) begin
            off_q <= start_offset;
            cnt_q <= num_words;
        end else if (stream_load) begin
            cnt_q <= cnt_q - LEN_W'(1);
        end
    end

    // Residual register keeps the most recently accepted beat for the next merge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            residual <= '0;
        end else if (in_fire) begin
            residual <= in_data;
        end
    end

    // Output register: load a merged word, or clear valid once the word is taken; otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (stream_load) begin
            out_valid <= 1'b1;
            out_last  <= final_load;
            out_data  <= merged;
        end else if (out_fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // done pulses after a zero-length start or after the final word is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= (start_ok && (num_words == '0)) || ((state == DRAIN) && out_fire);
        end
    end

`ifdef STREAM_REALIGNER_PERF_CNT_EN
    // Saturating count of back-pressured output cycles; restarts with each accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
        end else if (start_ok) begin
            stall_cnt <= 32'd0;
        end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_realigner.sv
// tb_stream_realigner
//   Randomised bench for stream_realigner. Expected words are built
//   byte-by-byte from the source beats in a queue. Handshakes, busy/done
//   timing, beat consumption and output stability are checked every cycle.
module tb_stream_realigner;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       start_offset = 4'd0;
    logic [LEN_W-1:0] num_words = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [127:0]     in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [127:0]     out_data;
    logic             out_last;
    logic             busy;
    logic             done;
    logic [1:0]       state_dbg;
`ifdef STREAM_REALIGNER_PERF_CNT_EN
    logic [31:0]      stall_cnt;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int stall_model = 0;
    logic [127:0] exp_q[$];
    logic [127:0] src[$];

    // Clock block.
    always #5 clk = ~clk;

    stream_realigner #(.LEN_W(LEN_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .start_offset(start_offset),
        .num_words(num_words),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy),
        .done(done),
`ifdef STREAM_REALIGNER_PERF_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .state_dbg(state_dbg)
    );

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference model: output word k byte j = byte (j+off) of the stream formed by the source beats.
    task automatic build_expected(input int off, input int nw);
        logic [127:0] w;
        logic [127:0] b;
        int p;
        exp_q.delete();
        for (int k = 0; k < nw; k++) begin
            w = '0;
            for (int j = 0; j < 16; j++) begin
                p = j + off;
                if (p < 16) begin
                    b = src[k];
                end else begin
                    b = src[k + 1];
                    p = p - 16;
                end
                w[8*j +: 8] = b[8*p +: 8];
            end
            exp_q.push_back(w);
        end
    endtask

    // Driver + scoreboard for one transfer. Inputs are driven on the falling edge.
    // Outputs are sampled 1 ns later, and the expectations for the next cycle are then updated.
    task automatic run_transfer(input int off, input int nw, input int vpct, input int rpct,
                                input int stall_n, input bit spam,
                                output int first_cyc, output int last_cyc);
        int need, bi, cyc, stall_left, after, budget;
        bit busy_exp, done_exp, fin, in_fire, out_fire, hold;
        logic [127:0] held_data;
        logic held_last;
        logic [127:0] w;
        need = (nw == 0) ? 0 : ((off == 0) ? nw : nw + 1);
        src.delete();
        for (int i = 0; i < need + 2; i++) src.push_back(rand128());
        build_expected(off, nw);
        bi = 0; cyc = 0; after = 0; stall_left = stall_n;
        busy_exp = 0; done_exp = 0; fin = 0; hold = 0;
        held_data = '0; held_last = 1'b0;
        first_cyc = -1; last_cyc = -1;
        stall_model = 0;
        budget = 20 * (nw + 4) + 50;
        while (after < 3) begin
            @(negedge clk);
            if (cyc == 0) begin
                start = 1'b1; start_offset = 4'(off); num_words = LEN_W'(nw);
            end else if (spam && busy_exp && ($urandom_range(0, 2) == 0)) begin
                start = 1'b1; start_offset = 4'($urandom()); num_words = LEN_W'($urandom());
            end else begin
                start = 1'b0;
            end
            in_valid = ($urandom_range(0, 99) < vpct);
            in_data = (bi < src.size()) ? src[bi] : rand128();
            out_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 99) < rpct);
            #1;
            n_checks++;
            if (busy !== busy_exp) begin
                n_fail++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, busy_exp);
            end
            n_checks++;
            if (done !== done_exp) begin
                n_fail++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, done_exp);
            end
            if (bi >= need) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL in_ready_after_last_beat cyc=%0d got=%b exp=0", cyc, in_ready);
                end
            end
            if (hold) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
                    n_fail++;
                    $display("FAIL hold_stable cyc=%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                             cyc, out_valid, out_data, out_last, held_data, held_last);
                end
            end
            in_fire = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            hold = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            if (out_valid && !out_ready) stall_model++;
            if (out_valid && stall_left > 0) stall_left--;
            if (out_fire) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL extra_word cyc=%0d got=%h exp=none", cyc, out_data);
                end else begin
                    w = exp_q.pop_front();
                    if (out_data !== w) begin
                        n_fail++; $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_data, w);
                    end
                    n_checks++;
                    if (out_last !== (exp_q.size() == 0)) begin
                        n_fail++; $display("FAIL out_last cyc=%0d got=%b exp=%b", cyc, out_last, exp_q.size() == 0);
                    end
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                end
            end
            if (in_fire) bi++;
            done_exp = 1'b0;
            if (cyc == 0) begin
                busy_exp = (nw != 0);
                done_exp = (nw == 0);
                fin = (nw == 0);
            end else if (out_fire && !fin && exp_q.size() == 0) begin
                busy_exp = 1'b0;
                done_exp = 1'b1;
                fin = 1'b1;
            end
            if (fin) after++;
            cyc++;
            if (cyc > budget) begin
                n_checks++; n_fail++;
                $display("FAIL timeout off=%0d nw=%0d got=%0d_cycles exp<=%0d", off, nw, cyc, budget);
                break;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (bi != need) begin
            n_fail++; $display("FAIL beats_consumed off=%0d nw=%0d got=%0d exp=%0d", off, nw, bi, need);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL missing_words off=%0d nw=%0d got=%0d_left exp=0", off, nw, exp_q.size());
        end
`ifdef STREAM_REALIGNER_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 32'(stall_model)) begin
            n_fail++; $display("FAIL stall_cnt off=%0d nw=%0d got=%0d exp=%0d", off, nw, stall_cnt, stall_model);
        end
`endif
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 128'd0 ||
            busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s got v=%b l=%b d=%h busy=%b done=%b in_ready=%b exp all 0",
                     tag, out_valid, out_last, out_data, busy, done, in_ready);
        end
`ifdef STREAM_REALIGNER_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 32'd0) begin
            n_fail++; $display("FAIL %s_stall_cnt got=%0d exp=0", tag, stall_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1; num_words = LEN_W'(3); in_valid = 1'b1; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_all_zero("reset_state");
        end
        start = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_aligned();
        int f, l;
        run_transfer(0, 3, 100, 100, 0, 0, f, l);
        n_checks++;
        if (f != 2 || l != 4) begin
            n_fail++; $display("FAIL aligned_timing got first=%0d last=%0d exp first=2 last=4", f, l);
        end
    endtask

    task automatic test_offset5();
        int f, l;
        run_transfer(5, 2, 100, 100, 0, 0, f, l);
        n_checks++;
        if (f != 3 || l != 4) begin
            n_fail++; $display("FAIL offset5_timing got first=%0d last=%0d exp first=3 last=4", f, l);
        end
    endtask

    task automatic test_stall();
        int f, l;
        run_transfer(15, 1, 100, 100, 4, 0, f, l);
        n_checks++;
        if (stall_model != 4) begin
            n_fail++; $display("FAIL stall_cycles got=%0d exp=4", stall_model);
        end
    endtask

    task automatic test_zero_len();
        int f, l;
        run_transfer(3, 0, 100, 100, 0, 0, f, l);
        run_transfer(0, 0, 100, 100, 0, 0, f, l);
        n_checks++;
        if (f != -1) begin
            n_fail++; $display("FAIL zero_len_word got first=%0d exp=-1", f);
        end
    endtask

    task automatic test_reset_mid();
        int f, l;
        src.delete();
        for (int i = 0; i < 6; i++) src.push_back(rand128());
        build_expected(0, 4);
        @(negedge clk);
        start = 1'b1; start_offset = 4'd0; num_words = LEN_W'(4); in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = src[0];
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_in_ready got=%b exp=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
            n_fail++; $display("FAIL mid_first_word got v=%b d=%h exp v=1 d=%h", out_valid, out_data, exp_q[0]);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_busy got=%b exp=1", busy);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (3) begin
            @(negedge clk);
            #1;
            check_all_zero("mid_reset_hold");
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_transfer(0, 1, 100, 100, 0, 0, f, l);
        n_checks++;
        if (f != 2) begin
            n_fail++; $display("FAIL after_reset_start got first=%0d exp=2", f);
        end
    endtask

    task automatic test_start_busy();
        int f, l;
        run_transfer(7, 6, 70, 60, 0, 1, f, l);
        run_transfer(0, 5, 80, 50, 0, 1, f, l);
    endtask

    task automatic test_back_to_back();
        int f, l;
        int off;
        off = $urandom_range(1, 15);
        run_transfer(off, 255, 100, 100, 0, 0, f, l);
        n_checks++;
        if (f != 3 || l - f != 254) begin
            n_fail++; $display("FAIL max_len_throughput got first=%0d span=%0d exp first=3 span=254", f, l - f);
        end
    endtask

    task automatic test_random();
        int f, l;
        for (int t = 0; t < 24; t++) begin
            run_transfer($urandom_range(0, 15), $urandom_range(1, 12),
                         $urandom_range(30, 100), $urandom_range(30, 100), 0, 0, f, l);
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_offset5();
        test_stall();
        test_zero_len();
        test_reset_mid();
        test_start_busy();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
